// File: rtl/noc_vc_input_buffer.sv
// rtl/noc_vc_input_buffer.sv - per-VC flit input buffer with backpressure and framing checks
//
// Receiver-side terminator of the NoC flit link. Each virtual channel owns a
// DEPTH-entry FIFO holding {header, tail, flit}. Backpressure comes from
// registered state only, and every VC checks its own packet framing.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      per-VC push handshake (in_ready = VC not full)
//   in_flit, in_is_header,   flit lanes: CHANNEL lanes, or a single shared
//   in_is_tail               lane when SHARED_BUS != 0
//   vc_ready                 registered early warning: VC has >= 2 free slots
//   out_valid / out_ready    per-VC pop handshake
//   out_flit, out_is_header, head entry of each VC FIFO
//   out_is_tail
//   occupancy                per-VC flit count, $clog2(DEPTH+1) bits each
//   frame_err                sticky per-VC framing violation
//   multi_err                sticky: more than one in_valid bit in shared mode
module noc_vc_input_buffer #(
  parameter int CHANNEL    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int SHARED_BUS = 0,
  localparam int FN        = (SHARED_BUS != 0) ? 1 : CHANNEL,
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNEL-1:0]            in_valid,
  output logic [CHANNEL-1:0]            in_ready,
  input  logic [FN*DATA_WIDTH-1:0]      in_flit,
  input  logic [FN-1:0]                 in_is_header,
  input  logic [FN-1:0]                 in_is_tail,
  output logic [CHANNEL-1:0]            vc_ready,
  output logic [CHANNEL-1:0]            out_valid,
  input  logic [CHANNEL-1:0]            out_ready,
  output logic [CHANNEL*DATA_WIDTH-1:0] out_flit,
  output logic [CHANNEL-1:0]            out_is_header,
  output logic [CHANNEL-1:0]            out_is_tail,
  output logic [CHANNEL*OW-1:0]         occupancy,
  output logic [CHANNEL-1:0]            frame_err,
  output logic                          multi_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_IN_PKT = 1'b1
  } frame_state_t;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [CHANNEL-1:0] push_sel;
  logic [CHANNEL-1:0] push;
  logic [CHANNEL-1:0] pop;
  logic               multi_hit;

  // In shared mode only the lowest-index requester owns the single lane,
  // even if that VC happens to be full.
  always_comb begin
    push_sel  = in_valid;
    multi_hit = 1'b0;
    if (SHARED_BUS != 0) begin
      push_sel  = in_valid & (~in_valid + CHANNEL'(1));
      multi_hit = (in_valid & (in_valid - CHANNEL'(1))) != '0;
    end
  end

  assign push = push_sel & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      multi_err <= 1'b0;
    end else if (multi_hit) begin
      multi_err <= 1'b1;
    end
  end

  for (genvar v = 0; v < CHANNEL; v++) begin : g_vc
    localparam int LN = (SHARED_BUS != 0) ? 0 : v;

    logic [EW-1:0]         mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic [OW-1:0]         occ_next;
    logic                  vcr;
    logic                  ferr;
    frame_state_t          fstate;
    logic [DATA_WIDTH-1:0] lane_flit;
    logic                  lane_hdr;
    logic                  lane_tail;
    logic [EW-1:0]         head;

    assign lane_flit = in_flit[LN*DATA_WIDTH +: DATA_WIDTH];
    assign lane_hdr  = in_is_header[LN];
    assign lane_tail = in_is_tail[LN];

    assign occ_next = occ + OW'(push[v]) - OW'(pop[v]);

    // Payload storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk) begin
      if (!rst && push[v]) begin
        mem[wr_ptr] <= {lane_hdr, lane_tail, lane_flit};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
        vcr    <= 1'b1;
        ferr   <= 1'b0;
        fstate <= FR_IDLE;
      end else begin
        if (push[v]) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop[v]) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        occ <= occ_next;
        vcr <= (occ_next <= OW'(DEPTH - 2));

        // Framing advances only on accepted flits. A violating flit is
        // still stored; a stray header mid-packet starts a new packet.
        if (push[v]) begin
          case (fstate)
            FR_IDLE: begin
              if (!lane_hdr) begin
                ferr <= 1'b1;
              end
              fstate <= lane_tail ? FR_IDLE : FR_IN_PKT;
            end
            FR_IN_PKT: begin
              if (lane_hdr) begin
                ferr <= 1'b1;
              end
              fstate <= lane_tail ? FR_IDLE : FR_IN_PKT;
            end
            default: fstate <= FR_IDLE;
          endcase
        end
      end
    end

    assign head = mem[rd_ptr];

    assign in_ready[v]                          = (occ != OW'(DEPTH));
    assign out_valid[v]                         = (occ != '0);
    assign vc_ready[v]                          = vcr;
    assign frame_err[v]                         = ferr;
    assign occupancy[v*OW +: OW]                = occ;
    assign out_flit[v*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
    assign out_is_tail[v]                       = head[DATA_WIDTH];
    assign out_is_header[v]                     = head[DATA_WIDTH+1];
  end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// tb/tb_noc_vc_input_buffer.sv - scoreboard bench for noc_vc_input_buffer (lane and shared modes)
module tb_noc_vc_input_buffer;

  localparam int CH    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: per-VC lanes, index 1: shared bus
  logic [CH-1:0]    in_valid  [2];
  logic [CH-1:0]    in_ready  [2];
  logic [CH*DW-1:0] in_flit   [2];
  logic [CH-1:0]    in_hdr    [2];
  logic [CH-1:0]    in_tail   [2];
  logic [CH-1:0]    vc_ready  [2];
  logic [CH-1:0]    out_valid [2];
  logic [CH-1:0]    out_ready [2];
  logic [CH*DW-1:0] out_flit  [2];
  logic [CH-1:0]    out_hdr   [2];
  logic [CH-1:0]    out_tail  [2];
  logic [CH*OW-1:0] occ       [2];
  logic [CH-1:0]    frame_err [2];
  logic             multi_err [2];

  noc_vc_input_buffer #(.CHANNEL(CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SHARED_BUS(0)) u_lane (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_flit(in_flit[0]),
    .in_is_header(in_hdr[0]), .in_is_tail(in_tail[0]), .vc_ready(vc_ready[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_flit(out_flit[0]),
    .out_is_header(out_hdr[0]), .out_is_tail(out_tail[0]), .occupancy(occ[0]),
    .frame_err(frame_err[0]), .multi_err(multi_err[0])
  );

  noc_vc_input_buffer #(.CHANNEL(CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .SHARED_BUS(1)) u_shared (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_flit(in_flit[1][DW-1:0]),
    .in_is_header(in_hdr[1][0]), .in_is_tail(in_tail[1][0]), .vc_ready(vc_ready[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_flit(out_flit[1]),
    .out_is_header(out_hdr[1]), .out_is_tail(out_tail[1]), .occupancy(occ[1]),
    .frame_err(frame_err[1]), .multi_err(multi_err[1])
  );

  // Reference model: per-VC expected contents, counts and framing state.
  logic [DW+1:0] expq [2][CH][$];
  int            mocc    [2][CH];
  bit            min_pkt [2][CH];
  bit            mferr   [2][CH];
  bit            mmulti  [2];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int lowest(input logic [CH-1:0] vals);
    for (int i = 0; i < CH; i++) if (vals[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mmulti[m] = 0;
      for (int v = 0; v < CH; v++) begin
        expq[m][v].delete();
        mocc[m][v]    = 0;
        min_pkt[m][v] = 0;
        mferr[m][v]   = 0;
      end
    end
  endtask

  // Apply the coming clock edge to the model using the inputs now driven.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      int lo;
      lo = lowest(in_valid[m]);
      if (m == 1 && $countones(in_valid[m]) > 1) mmulti[m] = 1;
      for (int v = 0; v < CH; v++) begin
        int  ln;
        bit  sel, psh, pp, h, t;
        ln  = (m == 1) ? 0 : v;
        sel = (m == 1) ? (lo == v) : in_valid[m][v];
        psh = sel && (mocc[m][v] < DEPTH);
        pp  = (mocc[m][v] > 0) && out_ready[m][v];
        h   = in_hdr[m][ln];
        t   = in_tail[m][ln];
        if (psh) begin
          expq[m][v].push_back({h, t, in_flit[m][ln*DW +: DW]});
          if (min_pkt[m][v] ? h : !h) mferr[m][v] = 1;
          min_pkt[m][v] = !t;
        end
        mocc[m][v] += int'(psh) - int'(pp);
      end
    end
  endtask

  task automatic check_state();
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < CH; v++) begin
        chk($sformatf("in_ready m%0d vc%0d", m, v), in_ready[m][v], mocc[m][v] < DEPTH);
        chk($sformatf("out_valid m%0d vc%0d", m, v), out_valid[m][v], mocc[m][v] > 0);
        chk($sformatf("occupancy m%0d vc%0d", m, v), occ[m][v*OW +: OW], mocc[m][v]);
        chk($sformatf("vc_ready m%0d vc%0d", m, v), vc_ready[m][v], (DEPTH - mocc[m][v]) >= 2);
        chk($sformatf("frame_err m%0d vc%0d", m, v), frame_err[m][v], mferr[m][v]);
      end
      chk($sformatf("multi_err m%0d", m), multi_err[m], mmulti[m]);
    end
  endtask

  // Called at posedge+1: check post-edge state, then commit the driven inputs.
  task automatic tick();
    check_state();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      in_valid[m]  = '0;
      in_hdr[m]    = '0;
      in_tail[m]   = '0;
      out_ready[m] = '0;
      in_flit[m]   = '0;
    end
  endtask

  task automatic drive(input int m, input int v, input logic [DW-1:0] d, input bit h, input bit t);
    int ln;
    ln = (m == 1) ? 0 : v;
    in_valid[m][v]         = 1'b1;
    in_flit[m][ln*DW +: DW] = d;
    in_hdr[m][ln]          = h;
    in_tail[m][ln]         = t;
  endtask

  // Monitor: any handshake the DUT presents must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        for (int m = 0; m < 2; m++) begin
          for (int v = 0; v < CH; v++) begin
            if (out_valid[m][v] === 1'b1 && out_ready[m][v] === 1'b1) begin
              if (expq[m][v].size() == 0) begin
                chk($sformatf("pop_unexpected m%0d vc%0d", m, v), 1'b1, 1'b0);
              end else begin
                chk($sformatf("pop_data m%0d vc%0d", m, v),
                    {out_hdr[m][v], out_tail[m][v], out_flit[m][v*DW +: DW]},
                    expq[m][v].pop_front());
              end
            end
          end
        end
      end
    end
  end

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill VC1 with one 4-flit packet and hold it, then drain in order.
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      drive(0, 1, 64'(100 + i), i == 0, i == 3);
      tick();
    end
    clear_inputs();
    tick();
    out_ready[0][1] = 1'b1;
    repeat (5) tick();

    // VC0 full: a pop and a push request in the same cycle yields a pop only.
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      drive(0, 0, 64'(200 + i), i == 0, i == 3);
      tick();
    end
    clear_inputs();
    drive(0, 0, 64'hdead, 1'b1, 1'b1);
    out_ready[0][0] = 1'b1;
    tick();
    clear_inputs();
    out_ready[0][0] = 1'b1;
    repeat (4) tick();

    // Pointer wrap on VC2: keep one flit in flight through many push/pop pairs.
    clear_inputs();
    drive(0, 2, 64'd0, 1'b1, 1'b0);
    tick();
    for (int i = 1; i < 10; i++) begin
      clear_inputs();
      drive(0, 2, 64'(i), 1'b0, i == 9);
      out_ready[0][2] = 1'b1;
      tick();
    end
    clear_inputs();
    out_ready[0][2] = 1'b1;
    repeat (2) tick();

    // Framing: body flit into idle VC3, then a header inside a VC0 packet.
    clear_inputs();
    drive(0, 3, 64'h33, 1'b0, 1'b0);
    tick();
    clear_inputs();
    drive(0, 0, 64'h40, 1'b1, 1'b0);
    tick();
    clear_inputs();
    drive(0, 0, 64'h41, 1'b1, 1'b1);
    tick();
    clear_inputs();
    out_ready[0] = '1;
    repeat (3) tick();

    // Shared bus: two requesters -> only VC1 pushes; then one-hot VC3 traffic.
    clear_inputs();
    in_valid[1] = 4'b0110;
    in_flit[1][DW-1:0] = 64'h5151;
    in_hdr[1][0] = 1'b1;
    in_tail[1][0] = 1'b1;
    tick();
    clear_inputs();
    drive(1, 3, 64'h5300, 1'b1, 1'b0);
    tick();
    clear_inputs();
    drive(1, 3, 64'h5301, 1'b0, 1'b1);
    tick();
    clear_inputs();
    out_ready[1] = '1;
    repeat (3) tick();

    // Randomized traffic, mostly well-framed, on both instances.
    for (int n = 0; n < 1500; n++) begin
      clear_inputs();
      for (int v = 0; v < CH; v++) begin
        if ($urandom_range(1, 0) == 1) begin
          bit h;
          h = !min_pkt[0][v];
          if ($urandom_range(31, 0) == 0) h = !h;
          drive(0, v, {$urandom, $urandom}, h, $urandom_range(2, 0) == 0);
        end
      end
      out_ready[0] = 4'($urandom);
      if ($urandom_range(3, 0) != 0) begin
        int lo;
        bit h;
        in_valid[1] = 4'b0001 << $urandom_range(CH - 1, 0);
        if ($urandom_range(31, 0) == 0) in_valid[1] = in_valid[1] | 4'($urandom);
        lo = lowest(in_valid[1]);
        h = !min_pkt[1][lo];
        if ($urandom_range(31, 0) == 0) h = !h;
        in_flit[1][DW-1:0] = {$urandom, $urandom};
        in_hdr[1][0] = h;
        in_tail[1][0] = ($urandom_range(2, 0) == 0);
      end
      out_ready[1] = 4'($urandom);
      tick();
    end

    // Reset in the middle of a packet discards buffered flits.
    clear_inputs();
    drive(0, 0, 64'h77, 1'b1, 1'b0);
    drive(1, 0, 64'h78, 1'b1, 1'b0);
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    drive(0, 0, 64'h79, 1'b1, 1'b1);
    drive(1, 0, 64'h7a, 1'b1, 1'b1);
    tick();

    // Drain everything and confirm nothing was lost.
    clear_inputs();
    out_ready[0] = '1;
    out_ready[1] = '1;
    repeat (DEPTH + 2) tick();
    check_state();
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < CH; v++) begin
        chk($sformatf("drained m%0d vc%0d", m, v), 66'(expq[m][v].size()), 66'd0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
